// File: rtl/int_ctrl_if.sv
// RIB slave register port bundle for the interrupt controller.
// The master drives the write strobe, address and write data; the slave returns combinational read data.
interface int_ctrl_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, output addr_i, output data_i, input data_o);
  modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: edge/level pending latches, per-line enables, claim encoder, registered int_o.
// Macro INT_CTRL_SYNC_EN selects a 2-flop input synchroniser instead of a single register stage.
module int_ctrl #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [7:0]  RST_ENABLE  = 8'h00,
  parameter logic [7:0]  RST_TRIGGER = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  int_ctrl_if.slave        bus,
  input  logic [7:0]       irq_i,
  output logic [7:0]       int_o
);

  localparam logic [7:0] IRQ_MASK = 8'((9'd1 << NUM_IRQ) - 9'd1);

  localparam logic [5:0] A_ENABLE  = 6'h00;
  localparam logic [5:0] A_PENDING = 6'h01;
  localparam logic [5:0] A_TRIGGER = 6'h02;
  localparam logic [5:0] A_CLAIM   = 6'h03;
  localparam logic [5:0] A_RAW     = 6'h04;

  logic [7:0] en_q,   en_d;
  logic [7:0] trig_q, trig_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] irq_d_q;
  logic [7:0] int_q;
  logic [7:0] irq_s;
  logic [7:0] rise;
  logic [7:0] w1c;
  logic [7:0] active;
  logic [2:0] claim_id;
  logic [31:0] rd_data;
  logic [5:0] word;
  logic unused_bits;

  assign word        = bus.addr_i[7:2];
  assign unused_bits = ^{bus.addr_i[31:8], bus.addr_i[1:0], bus.data_i[31:8]};

`ifdef INT_CTRL_SYNC_EN
  logic [7:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i & IRQ_MASK;
      sync2_q <= sync1_q;
    end
  end
  assign irq_s = sync2_q;
`else
  logic [7:0] sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= irq_i & IRQ_MASK;
  end
  assign irq_s = sync_q;
`endif

  assign rise   = irq_s & ~irq_d_q;
  assign active = pend_q & en_q;

  always_comb begin
    en_d   = en_q;
    trig_d = trig_q;
    w1c    = '0;
    if (bus.we_i) begin
      case (word)
        A_ENABLE:  en_d   = bus.data_i[7:0] & IRQ_MASK;
        A_PENDING: w1c    = bus.data_i[7:0] & IRQ_MASK;
        A_TRIGGER: trig_d = bus.data_i[7:0] & IRQ_MASK;
        default:   ;
      endcase
    end
  end

  // A rise in the same cycle as its W1C keeps the bit set; level bits simply follow the line.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pend
    always_comb begin
      if (gi >= NUM_IRQ)
        pend_d[gi] = 1'b0;
      else if (trig_q[gi])
        pend_d[gi] = rise[gi] | (pend_q[gi] & ~w1c[gi]);
      else
        pend_d[gi] = irq_s[gi];
    end
  end

  // Lowest-numbered active line wins, so scan from the top down.
  always_comb begin
    claim_id = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (active[k]) claim_id = 3'(k);
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (word)
      A_ENABLE:  rd_data = {24'h0, en_q};
      A_PENDING: rd_data = {24'h0, pend_q};
      A_TRIGGER: rd_data = {24'h0, trig_q};
      A_CLAIM:   rd_data = (|active) ? {1'b1, 28'h0, claim_id} : 32'h0;
      A_RAW:     rd_data = {24'h0, irq_s};
      default:   rd_data = 32'h0;
    endcase
  end
  assign bus.data_o = rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= RST_ENABLE & IRQ_MASK;
      trig_q  <= RST_TRIGGER & IRQ_MASK;
      pend_q  <= '0;
      irq_d_q <= '0;
      int_q   <= '0;
    end else begin
      en_q    <= en_d;
      trig_q  <= trig_d;
      pend_q  <= pend_d;
      irq_d_q <= irq_s;
      int_q   <= pend_q & en_q;
    end
  end

  assign int_o = int_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: register map, edge/level latching, priority, masking, async reset.
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
  localparam int SX = 1;
`else
  localparam int SX = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] irq_i;
  logic [7:0] int_o;
  int         n_checks;
  int         n_errors;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .irq_i (irq_i),
    .int_o (int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.data_i = d;
    @(negedge clk);
    bus.we_i   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr_i = a;
    #1;
    check(tag, bus.data_o, exp);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    irq_i      = 8'h00;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h0;
    bus.data_i = 32'h0;
    step(3);
    rst = 1'b1;
    step(1);

    // Reset values
    read_chk("rst_enable",  32'h00, 32'h0000_0000);
    read_chk("rst_pending", 32'h04, 32'h0000_0000);
    read_chk("rst_trigger", 32'h08, 32'h0000_00FF);
    read_chk("rst_claim",   32'h0C, 32'h0000_0000);
    check("rst_int_o", {24'h0, int_o}, 32'h0);

    // Edge latch and W1C
    bus_write(32'h00, 32'h01);
    irq_i = 8'h01;
    step(1);
    irq_i = 8'h00;
    step(1 + SX);
    read_chk("edge_pending", 32'h04, 32'h0000_0001);
    check("edge_int_o_early", {24'h0, int_o}, 32'h0);
    step(1);
    check("edge_int_o", {24'h0, int_o}, 32'h01);
    read_chk("edge_claim", 32'h0C, 32'h8000_0000);
    bus_write(32'h04, 32'h01);
    check("w1c_int_o_hold", {24'h0, int_o}, 32'h01);
    step(1);
    check("w1c_int_o", {24'h0, int_o}, 32'h0);
    read_chk("w1c_pending", 32'h04, 32'h0);

    // Priority
    bus_write(32'h00, 32'hFF);
    irq_i = 8'h24;
    step(1);
    irq_i = 8'h00;
    step(2 + SX);
    read_chk("prio_claim2", 32'h0C, 32'h8000_0002);
    check("prio_int_o", {24'h0, int_o}, 32'h24);
    bus_write(32'h04, 32'h04);
    read_chk("prio_claim5", 32'h0C, 32'h8000_0005);
    bus_write(32'h04, 32'h20);
    read_chk("prio_none", 32'h0C, 32'h0);

    // Set/clear collision, then held-high line does not re-set
    irq_i = 8'h08;
    step(1 + SX);
    bus_write(32'h04, 32'h08);
    read_chk("collide_pending", 32'h04, 32'h08);
    bus_write(32'h04, 32'h08);
    read_chk("held_no_reset", 32'h04, 32'h00);
    irq_i = 8'h00;
    step(1 + SX);

    // Level mode
    bus_write(32'h08, 32'h00);
    irq_i = 8'h02;
    step(2 + SX);
    read_chk("level_pending", 32'h04, 32'h02);
    bus_write(32'h04, 32'h02);
    read_chk("level_w1c", 32'h04, 32'h02);
    irq_i = 8'h00;
    step(1 + SX);
    read_chk("level_drop_1", 32'h04, 32'h02);
    step(1);
    read_chk("level_drop_2", 32'h04, 32'h00);
    bus_write(32'h08, 32'hFFFF_FFFF);
    read_chk("trigger_width", 32'h08, 32'h0000_00FF);

    // Masking
    bus_write(32'h00, 32'h00);
    irq_i = 8'h10;
    step(1);
    irq_i = 8'h00;
    step(2 + SX);
    read_chk("mask_pending", 32'h04, 32'h10);
    check("mask_int_o", {24'h0, int_o}, 32'h0);
    bus_write(32'h00, 32'h10);
    check("enable_int_o_hold", {24'h0, int_o}, 32'h0);
    step(1);
    check("enable_int_o", {24'h0, int_o}, 32'h10);

    // RAW, unmapped offsets
    irq_i = 8'h81;
    step(1 + SX);
    read_chk("raw", 32'h10, 32'h81);
    read_chk("unmapped_rd", 32'h14, 32'h0);
    bus_write(32'h20, 32'hFF);
    read_chk("unmapped_wr", 32'h00, 32'h10);

    // Asynchronous reset between clock edges, mid-pulse
    bus_write(32'h00, 32'hFF);
    step(2);
    check("pre_rst_int_o", {24'h0, int_o}, 32'h91);
    #2;
    rst = 1'b0;
    #1;
    check("arst_int_o", {24'h0, int_o}, 32'h0);
    read_chk("arst_enable",  32'h00, 32'h0);
    read_chk("arst_pending", 32'h04, 32'h0);
    read_chk("arst_trigger", 32'h08, 32'hFF);
    read_chk("arst_raw",     32'h10, 32'h0);
    irq_i = 8'h00;
    step(2);
    rst = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
